// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB-to-ID bypass and load-use hazard detection.
// Optional BubbleCount/FlushCount perf counters are enabled by defining ID_EX_PERF_COUNTERS_EN.
//
// state  | meaning
// BUBBLE | EX entry is a no-op (after reset, Flush or a load-use bubble)
// VALID  | EX entry holds a real instruction
module id_ex_stage #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [NBits-1:0] ID_ReadData1,
  input  logic [NBits-1:0] ID_ReadData2,
  input  logic [NBits-1:0] ID_Immediate,
  input  logic [NBits-1:0] ID_PC_4,
  input  logic [31:0]      ID_Instr,
  input  logic [10:0]      ID_Ctrl,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic [NBits-1:0] WB_WriteData,
  output logic             EX_Valid,
  output logic [NBits-1:0] EX_ReadData1,
  output logic [NBits-1:0] EX_ReadData2,
  output logic [NBits-1:0] EX_Immediate,
  output logic [NBits-1:0] EX_PC_4,
  output logic [NBits-1:0] EX_Shamt,
  output logic [4:0]       EX_Rs,
  output logic [4:0]       EX_Rt,
  output logic [4:0]       EX_WriteReg,
  output logic [5:0]       EX_ALUFunction,
  output logic [25:0]      EX_JumpNoShifted,
  output logic [9:0]       EX_Ctrl,
  output logic             HazardStall
`ifdef ID_EX_PERF_COUNTERS_EN
  ,
  output logic [15:0]      BubbleCount,
  output logic [15:0]      FlushCount
`endif
);

  typedef enum logic {BUBBLE = 1'b0, VALID = 1'b1} stateT;

  stateT state, nextState;

  logic [4:0]       idRs, idRt, idRd, idShamt;
  logic [5:0]       idFunct;
  logic [25:0]      idJump;
  logic             idRegDst, idUsesRt;
  logic             exMemRead;
  logic             bypassRs, bypassRt;
  logic [NBits-1:0] rsData, rtData;
  logic             insertBubble;
  logic             unusedOpcode;

  assign idRs     = ID_Instr[25:21];
  assign idRt     = ID_Instr[20:16];
  assign idRd     = ID_Instr[15:11];
  assign idShamt  = ID_Instr[10:6];
  assign idFunct  = ID_Instr[5:0];
  assign idJump   = ID_Instr[25:0];
  assign idRegDst = ID_Ctrl[5];
  assign idUsesRt = ID_Ctrl[0];
  assign unusedOpcode = &{1'b0, ID_Instr[31:26]};

  // EX_Ctrl drops UsesRt, so MemRead sits one bit lower than in ID_Ctrl
  assign exMemRead = EX_Ctrl[3];

  // Register 0 is hardwired, so neither bypass nor hazard may match it
  assign bypassRs = WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == idRs);
  assign bypassRt = WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == idRt);
  assign rsData   = bypassRs ? WB_WriteData : ID_ReadData1;
  assign rtData   = bypassRt ? WB_WriteData : ID_ReadData2;

  assign EX_Valid    = (state == VALID);
  assign HazardStall = EX_Valid && exMemRead && (EX_Rt != 5'd0) &&
                       ((EX_Rt == idRs) || (idUsesRt && (EX_Rt == idRt)));

  assign insertBubble = Flush || (!Stall && HazardStall);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BUBBLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (Flush) begin
      nextState = BUBBLE;
    end else if (!Stall) begin
      nextState = HazardStall ? BUBBLE : VALID;
    end
  end

  // Bubbles only clear the control word; the datapath fields are left as-is
  always_ff @(posedge clk) begin
    if (!reset) begin
      EX_ReadData1     <= '0;
      EX_ReadData2     <= '0;
      EX_Immediate     <= '0;
      EX_PC_4          <= '0;
      EX_Shamt         <= '0;
      EX_Rs            <= '0;
      EX_Rt            <= '0;
      EX_WriteReg      <= '0;
      EX_ALUFunction   <= '0;
      EX_JumpNoShifted <= '0;
      EX_Ctrl          <= '0;
    end else if (insertBubble) begin
      EX_Ctrl <= '0;
    end else if (!Stall) begin
      EX_ReadData1     <= rsData;
      EX_ReadData2     <= rtData;
      EX_Immediate     <= ID_Immediate;
      EX_PC_4          <= ID_PC_4;
      EX_Shamt         <= {{(NBits-5){1'b0}}, idShamt};
      EX_Rs            <= idRs;
      EX_Rt            <= idRt;
      EX_WriteReg      <= idRegDst ? idRd : idRt;
      EX_ALUFunction   <= idFunct;
      EX_JumpNoShifted <= idJump;
      EX_Ctrl          <= ID_Ctrl[10:1];
    end
  end

`ifdef ID_EX_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      BubbleCount <= '0;
      FlushCount  <= '0;
    end else begin
      if (Flush && (FlushCount != 16'hFFFF)) begin
        FlushCount <= FlushCount + 16'd1;
      end
      if (!Flush && !Stall && HazardStall && (BubbleCount != 16'hFFFF)) begin
        BubbleCount <= BubbleCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the ID/EX entry.
module tb_id_ex_stage;
  localparam int NBits = 32;

  logic             clk = 1'b0;
  logic             reset, Stall, Flush;
  logic [NBits-1:0] ID_ReadData1, ID_ReadData2, ID_Immediate, ID_PC_4;
  logic [31:0]      ID_Instr;
  logic [10:0]      ID_Ctrl;
  logic             WB_RegWrite;
  logic [4:0]       WB_WriteReg;
  logic [NBits-1:0] WB_WriteData;
  logic             EX_Valid;
  logic [NBits-1:0] EX_ReadData1, EX_ReadData2, EX_Immediate, EX_PC_4, EX_Shamt;
  logic [4:0]       EX_Rs, EX_Rt, EX_WriteReg;
  logic [5:0]       EX_ALUFunction;
  logic [25:0]      EX_JumpNoShifted;
  logic [9:0]       EX_Ctrl;
  logic             HazardStall;
`ifdef ID_EX_PERF_COUNTERS_EN
  logic [15:0]      BubbleCount, FlushCount;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.NBits(NBits)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Immediate(ID_Immediate), .ID_PC_4(ID_PC_4),
    .ID_Instr(ID_Instr), .ID_Ctrl(ID_Ctrl),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .EX_Valid(EX_Valid), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Immediate(EX_Immediate), .EX_PC_4(EX_PC_4), .EX_Shamt(EX_Shamt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WriteReg(EX_WriteReg),
    .EX_ALUFunction(EX_ALUFunction), .EX_JumpNoShifted(EX_JumpNoShifted),
    .EX_Ctrl(EX_Ctrl), .HazardStall(HazardStall)
`ifdef ID_EX_PERF_COUNTERS_EN
    , .BubbleCount(BubbleCount), .FlushCount(FlushCount)
`endif
  );

  localparam logic [31:0] ADD_3_1_2 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] LW_4_1    = {6'h23, 5'd1, 5'd4, 16'd8};
  localparam logic [31:0] ADD_5_4_2 = {6'h00, 5'd4, 5'd2, 5'd5, 5'd0, 6'h20};
  localparam logic [31:0] ADDI_4_1  = {6'h08, 5'd1, 5'd4, 16'd3};
  localparam logic [31:0] ADD_6_0_2 = {6'h00, 5'd0, 5'd2, 5'd6, 5'd0, 6'h20};
  localparam logic [10:0] CTRL_R    = 11'b010_0_0_1_0_0_1_0_1;
  localparam logic [10:0] CTRL_LW   = 11'b000_1_0_0_1_0_1_1_0;
  localparam logic [10:0] CTRL_ADDI = 11'b000_1_0_0_0_0_1_0_0;

  typedef struct packed {
    logic             valid;
    logic [NBits-1:0] rd1, rd2, imm, pc4, shamt;
    logic [4:0]       rs, rt, wr;
    logic [5:0]       funct;
    logic [25:0]      jump;
    logic [9:0]       ctrl;
  } entryT;

  entryT       mdl;
  bit          mdlKnown = 1'b0;
  bit          mdlInit  = 1'b0;
  int unsigned mBubble  = 0;
  int unsigned mFlush   = 0;
  int          errors   = 0;
  int          checks   = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // What the ID instruction becomes once it sits in EX, from the pipeline rules
  function automatic entryT decodeId();
    entryT      e;
    logic [4:0] rs, rt;
    rs      = ID_Instr[25:21];
    rt      = ID_Instr[20:16];
    e.valid = 1'b1;
    e.rs    = rs;
    e.rt    = rt;
    e.rd1   = (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == rs) ? WB_WriteData : ID_ReadData1;
    e.rd2   = (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == rt) ? WB_WriteData : ID_ReadData2;
    e.imm   = ID_Immediate;
    e.pc4   = ID_PC_4;
    e.shamt = NBits'(ID_Instr[10:6]);
    e.wr    = ID_Ctrl[5] ? ID_Instr[15:11] : rt;
    e.funct = ID_Instr[5:0];
    e.jump  = ID_Instr[25:0];
    e.ctrl  = ID_Ctrl[10:1];
    return e;
  endfunction

  // A load in EX whose destination is a source the ID instruction actually reads
  function automatic bit mdlHazard();
    bit loadInFlight, readsDest;
    loadInFlight = mdl.valid && mdl.ctrl[3] && (mdl.rt != 5'd0);
    readsDest    = (ID_Instr[25:21] == mdl.rt) || (ID_Ctrl[0] && ID_Instr[20:16] == mdl.rt);
    return loadInFlight && readsDest;
  endfunction

  task automatic checkOutputs();
    checkEq("valid", EX_Valid, mdl.valid);
    checkEq("ctrl", EX_Ctrl, mdl.ctrl);
    if (mdlKnown) begin
      checkEq("rd1", EX_ReadData1, mdl.rd1);
      checkEq("rd2", EX_ReadData2, mdl.rd2);
      checkEq("imm", EX_Immediate, mdl.imm);
      checkEq("pc4", EX_PC_4, mdl.pc4);
      checkEq("shamt", EX_Shamt, mdl.shamt);
      checkEq("rs", EX_Rs, mdl.rs);
      checkEq("rt", EX_Rt, mdl.rt);
      checkEq("writeReg", EX_WriteReg, mdl.wr);
      checkEq("funct", EX_ALUFunction, mdl.funct);
      checkEq("jump", EX_JumpNoShifted, mdl.jump);
    end
`ifdef ID_EX_PERF_COUNTERS_EN
    checkEq("bubbleCount", BubbleCount, mBubble);
    checkEq("flushCount", FlushCount, mFlush);
`endif
  endtask

  // Inputs are already driven; check the combinational stall, advance model and DUT one edge
  task automatic doCycle();
    bit hz;
    #1;
    hz = mdlHazard();
    if (mdlInit) checkEq("hazard", HazardStall, hz);
    if (!reset) begin
      mdl      = '0;
      mdlKnown = 1'b1;
      mdlInit  = 1'b1;
      mBubble  = 0;
      mFlush   = 0;
    end else if (Flush) begin
      mdl.valid = 1'b0;
      mdl.ctrl  = '0;
      mdlKnown  = 1'b0;
      if (mFlush < 65535) mFlush++;
    end else if (!Stall) begin
      if (hz) begin
        mdl.valid = 1'b0;
        mdl.ctrl  = '0;
        mdlKnown  = 1'b0;
        if (mBubble < 65535) mBubble++;
      end else begin
        mdl      = decodeId();
        mdlKnown = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (mdlInit) checkOutputs();
  endtask

  task automatic setId(input logic [31:0] instr, input logic [10:0] ctrl,
                       input logic [NBits-1:0] rd1, input logic [NBits-1:0] rd2,
                       input logic [NBits-1:0] imm, input logic [NBits-1:0] pc4);
    ID_Instr     = instr;
    ID_Ctrl      = ctrl;
    ID_ReadData1 = rd1;
    ID_ReadData2 = rd2;
    ID_Immediate = imm;
    ID_PC_4      = pc4;
  endtask

  logic [NBits-1:0] snapRd1, snapPc4;
  logic [4:0]       snapWr;
  logic [9:0]       snapCtrl;

  initial begin
    reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    WB_RegWrite = 1'b0; WB_WriteReg = '0; WB_WriteData = '0;
    setId(ADD_3_1_2, CTRL_R, 32'h11, 32'h22, 32'h33, 32'h44);
    doCycle();
    doCycle();
    checkEq("rst_valid", EX_Valid, 1'b0);
    checkEq("rst_rd1", EX_ReadData1, 32'd0);
    reset = 1'b1;

    // Plain R-type load
    setId(ADD_3_1_2, CTRL_R, 32'd5, 32'd7, 32'd0, 32'h104);
    doCycle();
    checkEq("add_valid", EX_Valid, 1'b1);
    checkEq("add_rd1", EX_ReadData1, 32'd5);
    checkEq("add_wr", EX_WriteReg, 5'd3);

    // Load-use on Rs
    setId(LW_4_1, CTRL_LW, 32'h100, 32'd0, 32'd8, 32'h108);
    doCycle();
    setId(ADD_5_4_2, CTRL_R, 32'd11, 32'd22, 32'd0, 32'h10c);
    #1 checkEq("lu_hazard", HazardStall, 1'b1);
    doCycle();
    checkEq("lu_bubble", EX_Valid, 1'b0);
    #1 checkEq("lu_bubble_nohz", HazardStall, 1'b0);
    doCycle();
    checkEq("lu_reload", EX_Valid, 1'b1);
    checkEq("lu_reload_rs", EX_Rs, 5'd4);

    // Rt match ignored when the instruction does not read Rt
    setId(LW_4_1, CTRL_LW, 32'h100, 32'd0, 32'd8, 32'h110);
    doCycle();
    setId(ADDI_4_1, CTRL_ADDI, 32'd1, 32'd2, 32'd3, 32'h114);
    #1 checkEq("usesrt_off", HazardStall, 1'b0);
    doCycle();

    // WB bypass, including register 0 never matching
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd1; WB_WriteData = 32'hDEAD;
    setId(ADD_3_1_2, CTRL_R, 32'd0, 32'd9, 32'd0, 32'h118);
    doCycle();
    checkEq("byp_rs", EX_ReadData1, 32'hDEAD);
    WB_WriteReg = 5'd2; WB_WriteData = 32'hBEEF;
    doCycle();
    checkEq("byp_rt", EX_ReadData2, 32'hBEEF);
    WB_WriteReg = 5'd0; WB_WriteData = 32'hDEAD;
    setId(ADD_6_0_2, CTRL_R, 32'd0, 32'd9, 32'd0, 32'h11c);
    doCycle();
    checkEq("byp_r0", EX_ReadData1, 32'd0);
    WB_RegWrite = 1'b0;

    // Flush beats Stall, then Stall alone holds everything
    Flush = 1'b1; Stall = 1'b1;
    doCycle();
    checkEq("flush_stall", EX_Valid, 1'b0);
    Flush = 1'b0; Stall = 1'b0;
    setId(ADD_3_1_2, CTRL_R, 32'd5, 32'd7, 32'd0, 32'h120);
    doCycle();
    snapRd1 = EX_ReadData1; snapPc4 = EX_PC_4; snapWr = EX_WriteReg; snapCtrl = EX_Ctrl;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setId($urandom, 11'($urandom), $urandom, $urandom, $urandom, $urandom);
      doCycle();
      checkEq("stall_valid", EX_Valid, 1'b1);
      checkEq("stall_rd1", EX_ReadData1, 32'd5);
      checkEq("stall_pc4", EX_PC_4, 32'h120);
      checkEq("stall_wr", EX_WriteReg, 5'd3);
      checkEq("stall_ctrl", EX_Ctrl, CTRL_R[10:1]);
    end
    Stall = 1'b0;

    // Reset in the middle of a pending load-use
    setId(LW_4_1, CTRL_LW, 32'h100, 32'd0, 32'd8, 32'h124);
    doCycle();
    setId(ADD_5_4_2, CTRL_R, 32'd11, 32'd22, 32'd0, 32'h128);
    reset = 1'b0;
    doCycle();
    reset = 1'b1;
    checkEq("mid_rst_valid", EX_Valid, 1'b0);
    checkEq("mid_rst_rd1", EX_ReadData1, 32'd0);
    checkEq("mid_rst_rt", EX_Rt, 5'd0);
    checkEq("mid_rst_ctrl", EX_Ctrl, 10'd0);
    #1 checkEq("mid_rst_hz", HazardStall, 1'b0);
`ifdef ID_EX_PERF_COUNTERS_EN
    checkEq("mid_rst_bubbles", BubbleCount, 16'd0);
    checkEq("mid_rst_flushes", FlushCount, 16'd0);
`endif

    // Random traffic with a small register set so hazards and bypasses collide often
    for (int i = 0; i < 600; i++) begin
      logic [10:0] ctrl;
      reset = ($urandom_range(0, 59) != 0);
      Flush = ($urandom_range(0, 9) == 0);
      Stall = ($urandom_range(0, 6) == 0);
      ctrl  = 11'($urandom);
      ctrl[4] = ($urandom_range(0, 1) == 1);
      setId({6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)},
            ctrl, $urandom, $urandom, $urandom, $urandom);
      WB_RegWrite  = 1'($urandom);
      WB_WriteReg  = 5'($urandom_range(0, 7));
      WB_WriteData = $urandom;
      doCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
